// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// Holds the default widths, the register count and the
// controller state encoding.
package rf_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 32;

    // INIT clears the register file. RUN serves the writeback requesters.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of requester handshakes and register-file write-port signals.
//   master : the requester / register-file side (drives valid, addr, data).
//   slave  : the arbiter (drives ready, rf_we, rf_addr, rf_wd, init_done).
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wd;
    logic              init_done;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  rf_we, rf_addr, rf_wd, init_done
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output rf_we, rf_addr, rf_wd, init_done
    );
endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. It is purely combinational,
// and the pointer register lives in the parent.
//   valid[1:0] : request vector (bit 0 = req0)
//   ptr        : tie-break pointer (0 selects req0)
//   grant[1:0] : one-hot grant, or zero when no request
//   next_ptr   : after a grant, points at the non-granted requester
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       next_ptr
);
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
        if (grant[0]) begin
            next_ptr = 1'b1;
        end else if (grant[1]) begin
            next_ptr = 1'b0;
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Owner of the register-file write port (A3/WD3/WE3).
// After reset, the arbiter sweeps every register to zero because the storage
// has no reset. It then shares the port round-robin between req0 (ALU
// writeback) and req1 (load/multi-cycle writeback) through a registered
// output stage.
//   clk, reset : clock and synchronous active-high reset
//   bus        : requester handshakes, rf_we/rf_addr/rf_wd and init_done
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W    = RF_DATA_W,
    parameter int ADDR_W    = RF_ADDR_W,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    rf_write_arbiter_if.slave  bus
);
    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;

    logic              run;
    logic [1:0]        arb_valid;
    logic [1:0]        grant;
    logic              arb_next_ptr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign run = (state_q == RUN);

    // Valids are gated with RUN, so the ready outputs stay low during the sweep.
    assign arb_valid = {bus.req1_valid, bus.req0_valid} & {2{run}};

    rr_arb2 u_arb (
        .valid    (arb_valid),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .next_ptr (arb_next_ptr)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    assign sel_addr = grant[1] ? bus.req1_addr : bus.req0_addr;
    assign sel_data = grant[1] ? bus.req1_data : bus.req0_data;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_wd_d   = rf_wd_q;
        case (state_q)
            INIT: begin
                if (INIT_ZERO) begin
                    rf_we_d   = 1'b1;
                    rf_addr_d = cnt_q;
                    rf_wd_d   = '0;
                    cnt_d     = cnt_q + ADDR_W'(1);
                    if (cnt_q == '1) begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (grant != 2'b00) begin
                    rr_ptr_d = arb_next_ptr;
                    // x0 is hardwired to zero. The write is accepted but dropped,
                    // and the output stage keeps its previous addr/data.
                    if (sel_addr != '0) begin
                        rf_we_d   = 1'b1;
                        rf_addr_d = sel_addr;
                        rf_wd_d   = sel_data;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            rr_ptr_q  <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_wd_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_wd_q   <= rf_wd_d;
        end
    end

    assign bus.rf_we     = rf_we_q;
    assign bus.rf_addr   = rf_addr_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.init_done = run;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter.
// The reference model tracks the sweep index, the tie-break preference and the
// expected contents of the output stage. It derives these directly from the
// behavioural rules.
module tb_rf_write_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    rf_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .INIT_ZERO(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit          m_run;
    bit          m_pref;      // requester that wins a tie
    int          m_idx;       // number of sweep writes already issued
    logic [4:0]  m_addr;      // last written addr/data in the output stage
    logic [31:0] m_wd;
    bit          m_hold_ok;   // held addr/data are known exactly

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    endtask

    // Apply reset for one or more edges while valids are driven high. This
    // shows that readiness stays gated. Then release reset and reset the model.
    task automatic do_reset(input int edges);
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        repeat (edges) @(posedge clk);
        #1;
        chk("rst_we",    32'(bus.rf_we), 32'd0);
        chk("rst_addr",  32'(bus.rf_addr), 32'd0);
        chk("rst_wd",    bus.rf_wd, 32'd0);
        chk("rst_done",  32'(bus.init_done), 32'd0);
        chk("rst_rdy0",  32'(bus.req0_ready), 32'd0);
        chk("rst_rdy1",  32'(bus.req1_ready), 32'd0);
        reset = 1'b0;
        idle_inputs();
        m_run = 1'b0; m_pref = 1'b0; m_idx = 0;
        m_addr = '0; m_wd = '0; m_hold_ok = 1'b1;
    endtask

    // One clock cycle: present the requests, check readiness, let the edge
    // happen, then check the output stage.
    task automatic cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         output logic g0, output logic g1);
        logic        exp_we;
        logic        next_run;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (m_run) begin
            if (v0 && v1) begin
                g0 = (m_pref == 1'b0);
                g1 = !g0;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        chk("ready0", 32'(bus.req0_ready), 32'(g0));
        chk("ready1", 32'(bus.req1_ready), 32'(g1));

        exp_we   = 1'b0;
        next_run = m_run;
        if (!m_run) begin
            exp_we = 1'b1;
            m_addr = 5'(m_idx);
            m_wd   = '0;
            m_idx++;
            if (m_idx == 32) next_run = 1'b1;
            m_hold_ok = 1'b1;
        end else if (g0 || g1) begin
            m_pref = g0 ? 1'b1 : 1'b0;
            if ((g0 ? a0 : a1) != 5'd0) begin
                exp_we = 1'b1;
                m_addr = g0 ? a0 : a1;
                m_wd   = g0 ? d0 : d1;
                m_hold_ok = 1'b1;
            end else begin
                m_hold_ok = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        m_run = next_run;
        chk("rf_we", 32'(bus.rf_we), 32'(exp_we));
        if (m_hold_ok) begin
            chk("rf_addr", 32'(bus.rf_addr), 32'(m_addr));
            chk("rf_wd",   bus.rf_wd, m_wd);
        end
        chk("init_done", 32'(bus.init_done), 32'(m_run));
    endtask

    initial begin
        logic        g0, g1;
        logic        p0, p1;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;

        idle_inputs();

        // Full sweep from a clean reset, then one idle RUN cycle
        do_reset(2);
        repeat (33) cycle(0, 0, 0, 0, 0, 0, g0, g1);

        // Reset reasserted at cycle 10 of the sweep; sweep restarts at 0
        do_reset(1);
        repeat (9) cycle(0, 0, 0, 0, 0, 0, g0, g1);
        do_reset(1);
        repeat (32) cycle(0, 0, 0, 0, 0, 0, g0, g1);

        // Single req0 write, then idle (hold check)
        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, g0, g1);
        cycle(0, 0, 0, 0, 0, 0, g0, g1);

        // req1 write to x0: accepted, no write, preference returns to req0
        cycle(0, 0, 0, 1, 0, 32'h12345678, g0, g1);
        cycle(0, 0, 0, 0, 0, 0, g0, g1);

        // Both valid and held: grants alternate starting with req0
        repeat (4) cycle(1, 1, 32'hA1A1A1A1, 1, 2, 32'hB2B2B2B2, g0, g1);
        cycle(0, 0, 0, 0, 0, 0, g0, g1);

        // Requests raised during the sweep are held off until RUN
        do_reset(1);
        repeat (4) cycle(0, 0, 0, 0, 0, 0, g0, g1);
        p0 = 1'b1; p1 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cycle(p0, 9, 32'h0000_0009, p1, 10, 32'h0000_000A, g0, g1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
        end

        // Random traffic. Each requester holds its request until it is granted.
        p0 = 1'b0; p1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1'b1; a0 = 5'($urandom_range(0, 31)); d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1; a1 = 5'($urandom_range(0, 31)); d1 = $urandom;
            end
            cycle(p0, a0, d0, p1, a1, d1, g0, g1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
